sar_magnitude_search: RTL and testbench



---
 rtl/sar_magnitude_search.sv | 175 +++++++++++++++++
 tb/tb_sar_magnitude_search.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_magnitude_search.sv
// sar_magnitude_search
//
// Binary-search controller that locates an unknown WIDTH-bit value held
// behind an external combinational magnitude comparator. Each clock it
// presents a registered guess, samples the comparator flags against it and
// halves the [lo, hi] window until the comparator reports equality.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   start   in   begin a search (sampled only in IDLE)
//   eq      in   comparator: secret == guess
//   gt      in   comparator: secret >  guess
//   lt      in   comparator: secret <  guess
//   guess   out  operand driven to the comparator (registered)
//   busy    out  high while a search is in progress
//   done    out  one-cycle pulse at the end of a search
//   err     out  one-cycle pulse with done when the search failed
//   found   out  value located by the last successful search
//   probes  out  probes consumed by the last search
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; comparator flags are ignored
// PROBE | guess is on the comparator; flags evaluated every edge

module sar_magnitude_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] found,
    output logic [WIDTH-1:0] probes
);

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    localparam logic [WIDTH:0]   HI_INIT  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MID_INIT = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic [WIDTH-1:0] probes_q, probes_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Window arithmetic is one bit wider than the operand so lo+hi never wraps.
    logic [WIDTH:0] lo_up;
    logic [WIDTH:0] hi_dn;
    logic [WIDTH:0] sum_gt;
    logic [WIDTH:0] sum_lt;
    logic           onehot;
    logic           fail_c;
    logic           exit_c;

    assign lo_up  = {1'b0, guess_q} + {{WIDTH{1'b0}}, 1'b1};
    assign hi_dn  = {1'b0, guess_q} - {{WIDTH{1'b0}}, 1'b1};
    assign sum_gt = lo_up + hi_q;
    assign sum_lt = lo_q + hi_dn;

    always_comb begin
        onehot = 1'b0;
        case ({eq, gt, lt})
            3'b100, 3'b010, 3'b001: onehot = 1'b1;
            default:                onehot = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            guess_q  <= '0;
            found_q  <= '0;
            probes_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            found_q  <= found_d;
            probes_q <= probes_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        found_d  = found_q;
        probes_d = probes_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail_c   = 1'b0;
        exit_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = HI_INIT;
                    guess_d  = MID_INIT;
                    probes_d = '0;
                    state_d  = PROBE;
                end
            end
            PROBE: begin
                probes_d = probes_q + 1'b1;
                if (!onehot) begin
                    fail_c = 1'b1;
                end else if (eq) begin
                    found_d = guess_q;
                    exit_c  = 1'b1;
                end else if (gt) begin
                    // A guess at full scale cannot have a larger secret.
                    if (guess_q == ALL_ONES) begin
                        fail_c = 1'b1;
                    end else begin
                        lo_d = lo_up;
                        if (lo_up > hi_q) fail_c = 1'b1;
                        else              guess_d = sum_gt[WIDTH:1];
                    end
                end else begin
                    if (guess_q == '0) begin
                        fail_c = 1'b1;
                    end else begin
                        hi_d = hi_dn;
                        if (lo_q > hi_dn) fail_c = 1'b1;
                        else              guess_d = sum_lt[WIDTH:1];
                    end
                end

                if (fail_c || exit_c) begin
                    state_d = IDLE;
                    guess_d = '0;
                    done_d  = 1'b1;
                    err_d   = fail_c;
                end
            end
            default: begin
                state_d = IDLE;
                guess_d = '0;
            end
        endcase
    end

    assign guess  = guess_q;
    assign busy   = (state_q == PROBE);
    assign done   = done_q;
    assign err    = err_q;
    assign found  = found_q;
    assign probes = probes_q;

endmodule

// File: tb/tb_sar_magnitude_search.sv
module tb_sar_magnitude_search;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic         eq, gt, lt;
    logic [W-1:0] guess;
    logic         busy, done, err;
    logic [W-1:0] found;
    logic [W-1:0] probes;

    // comparator personality: 0 honest, 1 lt stuck high, 2 eq+gt, 3 no flags
    int           mode;
    logic [W-1:0] secret;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    int exp_q[$];
    bit exp_err;
    int exp_found;

    sar_magnitude_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .eq     (eq),
        .gt     (gt),
        .lt     (lt),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .found  (found),
        .probes (probes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        eq = 1'b0;
        gt = 1'b0;
        lt = 1'b0;
        case (mode)
            0: begin
                eq = (secret == guess);
                gt = (secret > guess);
                lt = (secret < guess);
            end
            1: lt = 1'b1;
            2: begin
                eq = 1'b1;
                gt = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: textbook binary search over [0, MAXV], midpoint rounded down,
    // with the comparator answer derived from the chosen personality.
    task automatic model(input int sec, input int md);
        int lo, hi, g, nflags;
        bit fe, fg, fl;
        exp_q.delete();
        exp_err = 1'b0;
        lo = 0;
        hi = MAXV;
        for (int step = 0; step < 32; step++) begin
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            case (md)
                0:       begin fe = (sec == g); fg = (sec > g); fl = (sec < g); end
                1:       begin fe = 0; fg = 0; fl = 1; end
                2:       begin fe = 1; fg = 1; fl = 0; end
                default: begin fe = 0; fg = 0; fl = 0; end
            endcase
            nflags = int'(fe) + int'(fg) + int'(fl);
            if (nflags != 1) begin exp_err = 1'b1; break; end
            if (fe) break;
            if (fg) begin
                if (g == MAXV) begin exp_err = 1'b1; break; end
                lo = g + 1;
            end else begin
                if (g == 0) begin exp_err = 1'b1; break; end
                hi = g - 1;
            end
            if (lo > hi) begin exp_err = 1'b1; break; end
        end
    endtask

    task automatic run_search(input int sec, input int md, input bit repulse);
        int n;
        bit got;
        secret = sec[W-1:0];
        mode   = md;
        model(sec, md);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("first_guess", guess, exp_q[0]);
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                got = 1'b1;
                break;
            end
            start = (repulse && n == 1);
            chk("busy_mid", busy, 1);
            if (n < exp_q.size()) chk("guess_seq", guess, exp_q[n]);
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("done_latency", n, exp_q.size());
        chk("err_flag", err, exp_err);
        if (!exp_err) exp_found = sec;
        chk("found", found, exp_found);
        chk("probes", probes, exp_q.size());
        chk("busy_exit", busy, 0);
        chk("guess_exit", guess, 0);
        @(posedge clk);
        #1;
        chk("done_pulse_width", done, 0);
        chk("err_pulse_width", err, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 0;
        secret    = '0;
        exp_found = 0;
        repeat (2) @(negedge clk);
        chk("rst_guess", guess, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_found", found, 0);
        chk("rst_probes", probes, 0);
        rst = 1'b0;

        // nonsense flags while idle must not start anything
        mode = 2;
        repeat (3) @(negedge clk);
        chk("idle_flags_busy", busy, 0);
        chk("idle_flags_done", done, 0);

        run_search(7, 0, 0);
        run_search(15, 0, 0);
        run_search(0, 0, 0);
        run_search(10, 0, 0);
        run_search(0, 1, 0);
        run_search(0, 2, 0);
        run_search(5, 3, 0);

        // asynchronous abort after the second probe
        secret = 4'd15;
        mode   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_abort_guess", guess, 13);
        rst = 1'b1;
        #1;
        chk("abort_guess", guess, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_found = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", done, 0);
        end
        run_search(15, 0, 0);

        // start re-pulsed mid-search is ignored
        run_search(13, 0, 1);

        for (int r = 0; r < 24; r++) begin
            int s, m;
            s = $urandom_range(0, MAXV);
            m = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            run_search(s, m, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
